// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single external memory bus.
// Round-robin grant with parking. The granted master's command passes
// straight through to the memory. Split read responses are routed back
// to the issuing master through a small in-order FIFO of master ids.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int MAX_PENDING = 4,
    parameter int PEND_LOG2   = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    // master 0 (test controller)
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [BE_WIDTH-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_readdataready,
    // master 1 (host loader / readback)
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [BE_WIDTH-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_readdataready,
    // memory side
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic [BE_WIDTH-1:0]   s_byteenable,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_WIDTH-1:0] s_writedata,
    input  logic                  s_waitrequest,
    input  logic [DATA_WIDTH-1:0] s_readdata,
    input  logic                  s_readdataready,
    // status
    output logic [1:0]            grant,
    output logic                  protocol_error
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [PEND_LOG2:0] FULL_COUNT = (PEND_LOG2 + 1)'(MAX_PENDING);

    state_t                 state, state_nxt;
    logic                   last;        // master that won the most recent acceptance
    logic                   req0, req1;
    logic                   accept;      // owner's command is taken this cycle
    logic                   push, pop;
    logic                   stall_rd;
    logic                   fifo_full, fifo_empty;
    logic                   head;
    logic                   fifo_mem [MAX_PENDING];
    logic [PEND_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [PEND_LOG2:0]     count;

    assign req0  = m0_read | m0_write;
    assign req1  = m1_read | m1_write;
    assign grant = state;

    // A response arriving this cycle frees a slot, so a read waiting on a
    // full FIFO can be accepted in the same cycle as the pop.
    assign fifo_full  = (count == FULL_COUNT) && !s_readdataready;
    assign fifo_empty = (count == '0);
    assign pop        = s_readdataready && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];

    // Read data is broadcast; only the strobe is routed.
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdataready = pop && !head;
    assign m1_readdataready = pop && head;

    // Bus pass-through for the owner, stall generation and next-state selection.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        s_address      = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        stall_rd       = 1'b0;
        accept         = 1'b0;
        push           = 1'b0;
        state_nxt      = state;

        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? OWN0 : OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
            end
            OWN0: begin
                stall_rd       = m0_read && fifo_full;
                s_address      = m0_address;
                s_byteenable   = m0_byteenable;
                s_read         = m0_read && !stall_rd;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                m0_waitrequest = s_waitrequest || stall_rd;
                accept         = req0 && !m0_waitrequest;
                push           = accept && m0_read;
                // never preempt an owner that is stalled mid-command
                if ((accept || !req0) && req1)
                    state_nxt = OWN1;
            end
            OWN1: begin
                stall_rd       = m1_read && fifo_full;
                s_address      = m1_address;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read && !stall_rd;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                m1_waitrequest = s_waitrequest || stall_rd;
                accept         = req1 && !m1_waitrequest;
                push           = accept && m1_read;
                if ((accept || !req1) && req0)
                    state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration state, round-robin history and sticky error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            last           <= 1'b1;
            protocol_error <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            if (accept)
                last <= (state == OWN1);
            if (s_readdataready && fifo_empty)
                protocol_error <= 1'b1;
        end
    end

    // Pending-read FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Pending-read FIFO storage: id of the master that issued each read.
    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= (state == OWN1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external memory bus (address/byteenable/read/write/writedata/readdata/readdataready/waitrequest) between two masters: m0 = test_controller, m1 = host loader/readback path.
- Round-robin grant with parking, pass-through of the granted master's command, in-order routing of split read responses (readdataready) back to the issuing master.
- Sits between the tester core and the memory controller, in the tester clock domain.

Parameters:
- ADDR_WIDTH, 20, memory word address width
- DATA_WIDTH, 16, data bus width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- MAX_PENDING, 4, max outstanding reads (power of 2, >=2)
- PEND_LOG2, 2, log2(MAX_PENDING)

Ports:
- clock  in  1  bus clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- mN_address  in  ADDR_WIDTH  master N address (N = 0,1; every mN_ port exists for both masters)
- mN_byteenable  in  BE_WIDTH  master N byte enables
- mN_read  in  1  master N read request
- mN_write  in  1  master N write request
- mN_writedata  in  DATA_WIDTH  master N write data
- mN_waitrequest  out  1  master N stall
- mN_readdata  out  DATA_WIDTH  read data, s_readdata broadcast to both masters
- mN_readdataready  out  1  read data valid for master N
- s_address  out  ADDR_WIDTH  memory address
- s_byteenable  out  BE_WIDTH  memory byte enables
- s_read  out  1  memory read
- s_write  out  1  memory write
- s_writedata  out  DATA_WIDTH  memory write data
- s_waitrequest  in  1  memory stall
- s_readdata  in  DATA_WIDTH  memory read data
- s_readdataready  in  1  memory read data valid
- grant  out  2  one-hot current owner, debug/status
- protocol_error  out  1  sticky: readdataready with no pending read

Behaviour:
- Reset: state IDLE, grant=00, last=1 (m0 wins first tie), pending FIFO empty, protocol_error=0; s_read=s_write=0, s_address/s_byteenable/s_writedata=0; both mN_waitrequest=1, mN_readdataready=0.
- reqN = mN_read | mN_write. Master asserting read and write together is illegal; not checked.
- States: IDLE, OWN0, OWN1 (grant one-hot = state).
- IDLE: no request -> stay; one request -> OWN of that master next cycle; both -> master != last. One-cycle arbitration latency from IDLE.
- OWNn: slave outputs driven combinationally from mn_*; non-owner waitrequest=1; owner waitrequest = s_waitrequest | stall_rd, stall_rd = mn_read & pending FIFO full; s_read gated by !stall_rd.
- Acceptance = owner request & !mn_waitrequest; on acceptance last<=n.
- Switching, evaluated only on an acceptance cycle or when owner has no request: other master requesting -> OWN(other) next cycle; else owner still requesting -> stay; else park (stay OWNn, no bus activity). Owner mid-stall (request held, waitrequest=1) is never preempted.
- Accepted read pushes owner id into pending FIFO (depth MAX_PENDING, PEND_LOG2+1-bit count).
- s_readdataready: pops FIFO head; mH_readdataready = s_readdataready & head==H, other master 0. Same-cycle push and pop allowed, count unchanged. FIFO full blocks new reads only; writes proceed.
- s_readdataready with FIFO empty: dropped, protocol_error<=1 until reset.
- Responses return in issue order; a master may receive data after losing grant.
- Reset mid-transaction: everything returns to reset values immediately (async); memory responses for pre-reset reads arriving afterwards raise protocol_error.

Test Plan:
- m0 alone writes 0x1234 to 0x00010, then reads -> grant 00->01 after 1 cycle, s_write one cycle with data 0x1234, m0_readdataready on return, m1_readdataready stays 0.
- m0 and m1 both request from IDLE -> m0 first; after m0's acceptance m1 granted next cycle; continuous requests alternate 01,10,01,10.
- s_waitrequest held high 3 cycles during m1 write while m0 requests -> grant stays 10 until acceptance, s_address stable, m0_waitrequest=1 throughout.
- Memory latency 6 cycles, m0 issues 5 back-to-back reads -> 4 accepted, 5th stalled until first readdataready, then accepted the same cycle as the pop; responses delivered in order.
- Interleaved reads m0,m1,m0 -> readdataready routed 0,1,0; s_readdataready with nothing pending -> protocol_error=1, no master strobe.
- Assert reset_n low while m1 owns with 2 reads pending -> grant=00, s_read=0 asynchronously; after release, late s_readdataready sets protocol_error.
